copro_host_master: RTL and testbench
====================================

Name: copro_host_master

Overview:
- Host-side initiator for the coprocessor register bus; the requesting end of the write-enable / write-bus / select-read / data-out interface.
- Accepts commands over a valid/ready stream: single write, single read, or poll-until-match on a status register.
- Drives `writeEnable`, `writeBus` and `selectRead`, captures `dataOut`, and returns one response per command.
- Sits between a host/CPU adapter and the coprocessor top level.

Parameters:
- DATA_W, 256, width of `writeBus` / `dataOut` / command and response data.
- ADDR_W, 4, register index width; `writeEnable` width is 2**ADDR_W.
- POLL_GAP, 4, idle cycles between successive poll reads (≥1).
- MAX_POLLS, 1024, poll reads issued before timeout (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved.
- cmd_addr  in  ADDR_W  register index.
- cmd_wdata  in  DATA_W  write data (write op only).
- cmd_mask  in  8  poll mask applied to `dataOut[7:0]`.
- cmd_match  in  8  poll compare value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  read/poll data; 0 for writes.
- rsp_err  out  1  1 = poll timeout or reserved op.
- writeEnable  out  2**ADDR_W  one-hot write strobe to coprocessor.
- writeBus  out  DATA_W  write data to coprocessor.
- selectRead  out  ADDR_W  read select to coprocessor.
- dataOut  in  DATA_W  combinational read data from coprocessor.

Behaviour:
- Interface: one clock `clock`; reset `reset_n` is asynchronous, active-low. All outputs are registered except `cmd_ready`, which is (state==IDLE).
- Reset (asynchronous, immediate, including mid-operation):
  - State IDLE; `writeEnable`=0, `writeBus`=0, `selectRead`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0; counters cleared.
  - Any in-flight command is dropped with no response.
- States: IDLE, WRITE, READ, POLL_READ, POLL_WAIT, RESP.
- IDLE: `cmd_valid` && `cmd_ready` at an edge accepts the command.
  - op 00: `writeEnable` <= 1<<`cmd_addr`, `writeBus` <= `cmd_wdata` -> WRITE.
  - op 01: `selectRead` <= `cmd_addr` -> READ.
  - op 10: `selectRead` <= `cmd_addr`, poll_cnt <= 1 -> POLL_READ.
  - op 11: no bus activity; `rsp_err` <= 1, `rsp_data` <= 0 -> RESP.
- WRITE: strobe is high for exactly one cycle. Next edge: `writeEnable` <= 0, `writeBus` holds its value, `rsp_data` <= 0, `rsp_err` <= 0, `rsp_valid` <= 1 -> RESP.
- READ: `dataOut` is valid during this cycle. Next edge: `rsp_data` <= `dataOut`, `rsp_err` <= 0, `rsp_valid` <= 1 -> RESP. Read latency is 2 edges from accept to `rsp_valid`.
- POLL_READ: at the edge, hit = ((`dataOut[7:0]` ^ `cmd_match`) & `cmd_mask`) == 0, using latched mask/match.
  - hit: `rsp_data` <= `dataOut`, `rsp_err` <= 0 -> RESP.
  - miss and poll_cnt == MAX_POLLS: `rsp_data` <= `dataOut`, `rsp_err` <= 1 -> RESP.
  - otherwise: gap_cnt <= POLL_GAP-1 -> POLL_WAIT.
  - Mask 0 always hits on the first read.
- POLL_WAIT: decrement gap_cnt; when it reaches 0, poll_cnt++ -> POLL_READ. `selectRead` is held throughout.
- RESP: `rsp_valid` and `rsp_data` / `rsp_err` are held stable until `rsp_valid` && `rsp_ready`. At that edge: `rsp_valid` <= 0 -> IDLE.
  - `cmd_ready` is low in RESP, so there is no back-to-back overlap.
  - Minimum command period: write/read 3 cycles at `rsp_ready`=1.
- `writeEnable` is never multi-hot, and never high outside WRITE.
- Back-to-back write then read of the same register returns the new value, because the coprocessor register updates at the write edge.
- `cmd_*` inputs are ignored outside IDLE. Command fields are latched at accept.

Decomposition:
- Package `copro_host_pkg`:
  - op codes OP_WRITE / OP_READ / OP_POLL / OP_RSVD.
  - state enum.
  - coprocessor register index constants: plaintext 0, iv 1, AES CSR write 3, SHA plaintext 4, digest1 6, SHA CSR 7, seed 8, PRNG CSR write 10, R/S/V 12-14.
  - read-select constants: plaintext 0, iv 1, ciphertext 2, AES CSR 3, seed 4, generated 5, PRNG CSR 6.
- Sub-module `copro_poll_timer` holds gap_cnt and poll_cnt. Inputs start, gap_done, limit; outputs gap_zero, at_limit.

Test Plan:
- Write op 00, addr 1, wdata 0xA5A5: `writeEnable`=0x0002 for exactly 1 cycle with `writeBus`=0xA5A5; `rsp_valid` 2 edges after accept, `rsp_data`=0, `rsp_err`=0.
- Read op 01, addr 3, `dataOut` model returns 0x5C: `selectRead`=3, `rsp_data`=0x5C, `rsp_err`=0; `writeEnable` stays 0.
- Poll addr 3, mask 0x04, match 0x04; model sets bit 2 after 10 cycles: `rsp_err`=0, `rsp_data[2]`=1, consecutive poll reads spaced POLL_GAP+1 cycles.
- Poll with MAX_POLLS=8, status never matches: exactly 8 poll reads, then `rsp_err`=1.
- Op 11: response in 1 edge with `rsp_err`=1 and no bus strobe. Also hold `rsp_ready`=0 for 5 cycles: `rsp_valid` / `rsp_data` stable and `cmd_ready`=0 throughout.
- Assert `reset_n` low during WRITE and during POLL_WAIT: `writeEnable`=0 and `rsp_valid`=0 immediately, without waiting for a clock edge; after release, the next command completes normally.

Source files
------------

// File: rtl/copro_host_pkg.sv
// Shared definitions for the coprocessor host master: op codes, FSM states,
// coprocessor register/read-select indices and the poll compare helper.
package copro_host_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_POLL_READ = 3'd3,
        ST_POLL_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    // Write-side register indices (one writeEnable bit each)
    localparam logic [3:0] REG_PLAINTEXT     = 4'd0;
    localparam logic [3:0] REG_IV            = 4'd1;
    localparam logic [3:0] REG_AES_CSR       = 4'd3;
    localparam logic [3:0] REG_SHA_PLAINTEXT = 4'd4;
    localparam logic [3:0] REG_DIGEST1       = 4'd6;
    localparam logic [3:0] REG_SHA_CSR       = 4'd7;
    localparam logic [3:0] REG_SEED          = 4'd8;
    localparam logic [3:0] REG_PRNG_CSR      = 4'd10;
    localparam logic [3:0] REG_R             = 4'd12;
    localparam logic [3:0] REG_S             = 4'd13;
    localparam logic [3:0] REG_V             = 4'd14;

    // Read-select indices
    localparam logic [3:0] SEL_PLAINTEXT  = 4'd0;
    localparam logic [3:0] SEL_IV         = 4'd1;
    localparam logic [3:0] SEL_CIPHERTEXT = 4'd2;
    localparam logic [3:0] SEL_AES_CSR    = 4'd3;
    localparam logic [3:0] SEL_SEED       = 4'd4;
    localparam logic [3:0] SEL_GENERATED  = 4'd5;
    localparam logic [3:0] SEL_PRNG_CSR   = 4'd6;

    // A masked-out bit never causes a miss, so mask 0 always hits.
    function automatic logic poll_hit(input logic [7:0] data,
                                      input logic [7:0] mask,
                                      input logic [7:0] match);
        return ((data ^ match) & mask) == 8'h00;
    endfunction

endpackage

// File: rtl/copro_poll_timer.sv
// Poll pacing counters: gap_cnt spaces successive poll reads, poll_cnt
// counts reads issued for the current poll command.
module copro_poll_timer #(
    parameter int POLL_GAP = 4,
    parameter int CNT_W    = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             arm_i,
    input  logic             tick_i,
    input  logic             gap_done_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             gap_zero_o,
    output logic             at_limit_o
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(POLL_GAP - 1);

    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] poll_q, poll_d;

    // Next-state for both counters; a finished gap advances the read count.
    always_comb begin
        gap_d  = gap_q;
        poll_d = poll_q;
        if (start_i) begin
            poll_d = CNT_W'(1'b1);
            gap_d  = {GAP_W{1'b0}};
        end else if (arm_i) begin
            gap_d = GAP_RELOAD;
        end else if (gap_done_i) begin
            poll_d = poll_q + CNT_W'(1'b1);
        end else if (tick_i) begin
            gap_d = gap_q - GAP_W'(1'b1);
        end else begin
            gap_d = gap_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_q  <= {GAP_W{1'b0}};
            poll_q <= {CNT_W{1'b0}};
        end else begin
            gap_q  <= gap_d;
            poll_q <= poll_d;
        end
    end

    assign gap_zero_o = (gap_q == {GAP_W{1'b0}});
    assign at_limit_o = (poll_q == limit_i);

endmodule

// File: rtl/copro_host_master.sv
// Host-side initiator for the coprocessor register bus: turns write/read/poll
// commands into writeEnable/writeBus/selectRead activity, one response each.
module copro_host_master
    import copro_host_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 4,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    input  logic [7:0]               cmd_mask,
    input  logic [7:0]               cmd_match,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [(1<<ADDR_W)-1:0]   writeEnable,
    output logic [DATA_W-1:0]        writeBus,
    output logic [ADDR_W-1:0]        selectRead,
    input  logic [DATA_W-1:0]        dataOut
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_POLLS + 1);
    localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(MAX_POLLS);
    localparam logic [NREG-1:0]  WE_ONE     = NREG'(1'b1);

    state_e            state_q, state_d;
    logic [NREG-1:0]   we_q, we_d;
    logic [DATA_W-1:0] wbus_q, wbus_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        mask_q, mask_d;
    logic [7:0]        match_q, match_d;

    logic start_s, arm_s, tick_s, gap_done_s, gap_zero_s, at_limit_s, hit_s;

    assign hit_s      = poll_hit(dataOut[7:0], mask_q, match_q);
    assign gap_done_s = tick_s & gap_zero_s;

    copro_poll_timer #(
        .POLL_GAP (POLL_GAP),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (start_s),
        .arm_i      (arm_s),
        .tick_i     (tick_s),
        .gap_done_i (gap_done_s),
        .limit_i    (POLL_LIMIT),
        .gap_zero_o (gap_zero_s),
        .at_limit_o (at_limit_s)
    );

    // Next-state and next-output logic for the command sequencer.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wbus_d      = wbus_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mask_d      = mask_q;
        match_d     = match_q;
        start_s     = 1'b0;
        arm_s       = 1'b0;
        tick_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            we_d    = WE_ONE << cmd_addr;
                            wbus_d  = cmd_wdata;
                            state_d = ST_WRITE;
                        end
                        OP_READ: begin
                            sel_d   = cmd_addr;
                            state_d = ST_READ;
                        end
                        OP_POLL: begin
                            sel_d   = cmd_addr;
                            mask_d  = cmd_mask;
                            match_d = cmd_match;
                            start_s = 1'b1;
                            state_d = ST_POLL_READ;
                        end
                        default: begin
                            rsp_err_d   = 1'b1;
                            rsp_data_d  = {DATA_W{1'b0}};
                            rsp_valid_d = 1'b1;
                            state_d     = ST_RESP;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                we_d        = {NREG{1'b0}};
                rsp_data_d  = {DATA_W{1'b0}};
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_READ: begin
                rsp_data_d  = dataOut;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_POLL_READ: begin
                if (hit_s || at_limit_s) begin
                    rsp_data_d  = dataOut;
                    rsp_err_d   = ~hit_s;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    arm_s   = 1'b1;
                    state_d = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                tick_s = 1'b1;
                if (gap_zero_s) begin
                    state_d = ST_POLL_READ;
                end else begin
                    state_d = ST_POLL_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                we_d        = {NREG{1'b0}};
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset drops any in-flight command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            we_q        <= {NREG{1'b0}};
            wbus_q      <= {DATA_W{1'b0}};
            sel_q       <= {ADDR_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            mask_q      <= 8'h00;
            match_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wbus_q      <= wbus_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mask_q      <= mask_d;
            match_q     <= match_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign writeEnable = we_q;
    assign writeBus    = wbus_q;
    assign selectRead  = sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_copro_host_master.sv
// Randomized self-checking bench for copro_host_master with a transaction-level
// reference model and a per-cycle output compare process.
module tb_copro_host_master;

    localparam int DW   = 256;
    localparam int GAP  = 4;
    localparam int MAXP = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_addr, selectRead;
    logic [DW-1:0] cmd_wdata, rsp_data, writeBus, dataOut;
    logic [7:0]    cmd_mask, cmd_match;
    logic [15:0]   writeEnable;

    copro_host_master #(.DATA_W(DW), .ADDR_W(4), .POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .cmd_match(cmd_match), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .writeEnable(writeEnable),
        .writeBus(writeBus), .selectRead(selectRead), .dataOut(dataOut)
    );

    always #5 clock = ~clock;

    // Coprocessor model: registers written by the strobe, plus a scheduled status bit.
    logic [DW-1:0] cop_mem [16];
    int cyc = 0;
    int fire_cyc = -1;
    logic [3:0] fire_addr = 4'd0;
    logic [DW-1:0] fire_val = '0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 16; i++)
            if (writeEnable[i]) cop_mem[i] <= writeBus;
        if (cyc == fire_cyc) cop_mem[fire_addr] <= cop_mem[fire_addr] | fire_val;
    end
    assign dataOut = cop_mem[selectRead];

    // Reference state and expected outputs
    logic [DW-1:0] ref_mem [16];
    bit            fired = 1'b1;
    logic [15:0]   exp_we = '0;
    logic [DW-1:0] exp_wbus = '0, exp_rdata = '0;
    logic [3:0]    exp_sel = '0;
    logic          exp_rv = 1'b0, exp_rerr = 1'b0, exp_rdy = 1'b1;
    bit            check_en = 1'b0, garble = 1'b0;
    int            checks = 0, errors = 0;
    int            acc_cyc = 0, last_lat = 0, we_cycles = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_rerr = 1'b0, prev_rv = 1'b0;
    logic [15:0]   last_we = '0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Per-cycle compare of DUT outputs against the reference expectations.
    always @(negedge clock) begin
        if (reset_n) begin
            if (writeEnable != 16'h0000) begin
                we_cycles++;
                last_we = writeEnable;
            end
            if (rsp_valid && !prev_rv) last_lat = cyc - acc_cyc + 1;
            if (rsp_valid) begin
                last_rdata = rsp_data;
                last_rerr  = rsp_err;
            end
            if (check_en) begin
                chk("we_onehot", {255'd0, ($countones(writeEnable) <= 1)}, 256'd1);
                chk("writeEnable", {240'd0, writeEnable}, {240'd0, exp_we});
                chk("writeBus", writeBus, exp_wbus);
                chk("selectRead", {252'd0, selectRead}, {252'd0, exp_sel});
                chk("cmd_ready", {255'd0, cmd_ready}, {255'd0, exp_rdy});
                chk("rsp_valid", {255'd0, rsp_valid}, {255'd0, exp_rv});
                if (exp_rv) begin
                    chk("rsp_data", rsp_data, exp_rdata);
                    chk("rsp_err", {255'd0, rsp_err}, {255'd0, exp_rerr});
                end
            end
            prev_rv = rsp_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (garble) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_addr  = 4'($urandom_range(0, 15));
            cmd_wdata = rnd256();
            cmd_mask  = 8'($urandom);
            cmd_match = 8'($urandom);
        end
    endtask

    task automatic apply_fire();
        if (!fired && cyc > fire_cyc) begin
            ref_mem[fire_addr] = ref_mem[fire_addr] | fire_val;
            fired = 1'b1;
        end
    endtask

    // Issue one command and predict its bus activity and response from the op rules.
    task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [DW-1:0] wd,
                        input logic [7:0] mk, input logic [7:0] mt, input int hold);
        logic [DW-1:0] v;
        logic          hit;
        apply_fire();
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        cmd_mask = mk; cmd_match = mt;
        step();
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        garble = 1'b1;
        exp_rdy = 1'b0;
        case (op)
            2'b00: begin
                exp_we = 16'h0001 << addr;
                exp_wbus = wd;
                step();
                exp_we = 16'h0000;
                ref_mem[addr] = wd;
                exp_rv = 1'b1; exp_rdata = '0; exp_rerr = 1'b0;
            end
            2'b01: begin
                exp_sel = addr;
                apply_fire();
                v = ref_mem[addr];
                step();
                exp_rv = 1'b1; exp_rdata = v; exp_rerr = 1'b0;
            end
            2'b10: begin
                exp_sel = addr;
                for (int k = 1; k <= MAXP; k++) begin
                    apply_fire();
                    v = ref_mem[addr];
                    hit = (((v[7:0] ^ mt) & mk) == 8'h00);
                    step();
                    if (hit || k == MAXP) begin
                        exp_rv = 1'b1; exp_rdata = v; exp_rerr = ~hit;
                        break;
                    end
                    repeat (GAP) step();
                end
            end
            default: begin
                exp_rv = 1'b1; exp_rdata = '0; exp_rerr = 1'b1;
            end
        endcase
        repeat (hold) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        garble = 1'b0;
        cmd_valid = 1'b0;
        exp_rv = 1'b0;
        exp_rdy = 1'b1;
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_we"}, {240'd0, writeEnable}, 256'd0);
        chk({tag, "_rv"}, {255'd0, rsp_valid}, 256'd0);
        chk({tag, "_sel"}, {252'd0, selectRead}, 256'd0);
        chk({tag, "_rdy"}, {255'd0, cmd_ready}, 256'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
        exp_we = '0; exp_wbus = '0; exp_sel = '0; exp_rv = 1'b0; exp_rdy = 1'b1;
        @(posedge clock);
        #1 check_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [DW-1:0] d;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'd0;
        cmd_wdata = '0; cmd_mask = 8'h00; cmd_match = 8'h00; rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        #3;
        chk("reset_we", {240'd0, writeEnable}, 256'd0);
        chk("reset_wbus", writeBus, 256'd0);
        chk("reset_sel", {252'd0, selectRead}, 256'd0);
        chk("reset_rv", {255'd0, rsp_valid}, 256'd0);
        chk("reset_rdata", rsp_data, 256'd0);
        chk("reset_rerr", {255'd0, rsp_err}, 256'd0);
        chk("reset_rdy", {255'd0, cmd_ready}, 256'd1);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1 check_en = 1'b1;

        for (int i = 0; i < 16; i++) send(2'b00, 4'(i), rnd256(), 8'h00, 8'h00, 0);

        w0 = we_cycles;
        send(2'b00, 4'd1, 256'hA5A5, 8'h00, 8'h00, 1);
        chk("wr_strobe_cycles", 256'(we_cycles - w0), 256'd1);
        chk("wr_strobe_value", {240'd0, last_we}, 256'h0002);
        chk("wr_latency", 256'(last_lat), 256'd2);
        chk("wr_rsp_data", last_rdata, 256'd0);

        send(2'b00, 4'd3, 256'h5C, 8'h00, 8'h00, 0);
        w0 = we_cycles;
        send(2'b01, 4'd3, '0, 8'h00, 8'h00, 2);
        chk("rd_data", last_rdata, 256'h5C);
        chk("rd_latency", 256'(last_lat), 256'd2);
        chk("rd_no_strobe", 256'(we_cycles - w0), 256'd0);

        send(2'b00, 4'd3, 256'h58, 8'h00, 8'h00, 0);
        fire_addr = 4'd3; fire_val = 256'h4; fired = 1'b0; fire_cyc = cyc + 10;
        send(2'b10, 4'd3, '0, 8'h04, 8'h04, 0);
        chk("poll_err", {255'd0, last_rerr}, 256'd0);
        chk("poll_bit2", {255'd0, last_rdata[2]}, 256'd1);

        d = ref_mem[5];
        send(2'b10, 4'd5, '0, 8'hFF, ~d[7:0], 0);
        chk("poll_to_err", {255'd0, last_rerr}, 256'd1);
        chk("poll_to_latency", 256'(last_lat), 256'd37);

        send(2'b10, 4'd7, '0, 8'h00, 8'hFF, 0);
        chk("poll_mask0_latency", 256'(last_lat), 256'd2);
        chk("poll_mask0_err", {255'd0, last_rerr}, 256'd0);

        w0 = we_cycles;
        send(2'b11, 4'd2, '0, 8'h00, 8'h00, 5);
        chk("rsvd_latency", 256'(last_lat), 256'd1);
        chk("rsvd_err", {255'd0, last_rerr}, 256'd1);
        chk("rsvd_no_strobe", 256'(we_cycles - w0), 256'd0);

        // Reset in the middle of a write strobe.
        check_en = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'd6; cmd_wdata = rnd256();
        step();
        cmd_valid = 1'b0;
        async_reset("rst_write");
        d = rnd256();
        send(2'b00, 4'd6, d, 8'h00, 8'h00, 0);
        send(2'b01, 4'd6, '0, 8'h00, 8'h00, 0);
        chk("rst_write_readback", last_rdata, d);

        // Reset while waiting between poll reads.
        check_en = 1'b0;
        d = ref_mem[5];
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd5;
        cmd_mask = 8'hFF; cmd_match = ~d[7:0];
        step();
        cmd_valid = 1'b0;
        step();
        async_reset("rst_pollwait");
        send(2'b01, 4'd5, '0, 8'h00, 8'h00, 0);
        chk("rst_pollwait_read", last_rdata, ref_mem[5]);

        for (int n = 0; n < 60; n++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rnd256(),
                 8'($urandom), 8'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
